// File: rtl/spi_bootload_seq.sv
// Loader-register sequencer for flash CMD / PROGRAM / READ page operations over a 4-register bus.
// Build macro SPI_BOOTLOAD_SEQ_TIMEOUT_EN bounds each bus_valid_i wait to TIMEOUT cycles.
`timescale 1ns/1ps
module spi_bootload_seq #(
  parameter int unsigned NWORDS  = 256,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] cmd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] result_o,
  input  logic [15:0] src_dat_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  output logic [15:0] snk_dat_o,
  output logic        snk_valid_o,
  output logic [1:0]  bus_adr_o,
  output logic [15:0] bus_dat_o,
  output logic        bus_en_o,
  output logic        bus_wr_o,
  input  logic [15:0] bus_dat_i,
  input  logic        bus_valid_i
);
  localparam logic [1:0] OP_CMD  = 2'd0;
  localparam logic [1:0] OP_PROG = 2'd1;
  localparam logic [1:0] OP_READ = 2'd2;

  localparam logic [1:0] REG_FIFO = 2'd0;
  localparam logic [1:0] REG_ALO  = 2'd1;
  localparam logic [1:0] REG_AHI  = 2'd2;
  localparam logic [1:0] REG_CMD  = 2'd3;

  localparam logic [8:0]    CNT_LAST = 9'(NWORDS - 1);
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FRST, PUSH, WR_ALO, WR_AHI, WR_CMD, RD_CMD, WT_CMD, RD_DAT, WT_DAT, DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    op_q;
  logic [31:0]   addr_q;
  logic [15:0]   cmd_q;
  logic [8:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic          busy_q, done_q, err_q, snk_valid_q, en_q, wr_q;
  logic [15:0]   result_q, snk_dat_q, dat_q;
  logic [1:0]    adr_q;
  logic          push_wr, tmo_hit;

  // A PUSH write happens in the very cycle the source word is accepted.
  assign push_wr     = (state_q == PUSH) && src_valid_i;
  assign tmo_hit     = (tmo_q == TMO_LAST);

  assign src_ready_o = push_wr;
  assign bus_en_o    = en_q | push_wr;
  assign bus_wr_o    = wr_q | push_wr;
  assign bus_dat_o   = push_wr ? src_dat_i : dat_q;
  assign bus_adr_o   = adr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign result_o    = result_q;
  assign snk_dat_o   = snk_dat_q;
  assign snk_valid_o = snk_valid_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q     <= IDLE;
      op_q        <= OP_CMD;
      addr_q      <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      snk_valid_q <= 1'b0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      result_q    <= '0;
      snk_dat_q   <= '0;
      dat_q       <= '0;
      adr_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      snk_valid_q <= 1'b0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            op_q   <= op_i;
            addr_q <= addr_i;
            cmd_q  <= cmd_i;
            unique case (op_i)
              OP_CMD: begin
                state_q <= WR_ALO;
                {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_ALO, addr_i[15:0]};
              end
              OP_PROG: begin
                state_q <= PUSH;
                adr_q   <= REG_FIFO;
              end
              OP_READ: begin
                state_q <= FRST;
                {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_FIFO, 16'h8000};
              end
              default: begin
                state_q <= DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        FRST: begin
          state_q <= WR_ALO;
          {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_ALO, addr_q[15:0]};
        end
        PUSH: begin
          if (src_valid_i) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= WR_ALO;
              {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_ALO, addr_q[15:0]};
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        WR_ALO: begin
          state_q <= WR_AHI;
          {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_AHI, addr_q[31:16]};
        end
        WR_AHI: begin
          state_q <= WR_CMD;
          {en_q, wr_q, adr_q, dat_q} <= {2'b11, REG_CMD, cmd_q};
        end
        WR_CMD: begin
          state_q <= RD_CMD;
          {en_q, wr_q, adr_q} <= {2'b10, REG_CMD};
        end
        RD_CMD: begin
          state_q <= WT_CMD;
          tmo_q   <= '0;
        end
        WT_CMD: begin
          if (bus_valid_i) begin
            result_q <= bus_dat_i;
            if (op_q == OP_READ) begin
              state_q <= RD_DAT;
              {en_q, wr_q, adr_q} <= {2'b10, REG_FIFO};
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (tmo_hit) begin
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RD_DAT: begin
          state_q <= WT_DAT;
          tmo_q   <= '0;
        end
        WT_DAT: begin
          if (bus_valid_i) begin
            snk_dat_q   <= bus_dat_i;
            snk_valid_q <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 9'd1;
              state_q <= RD_DAT;
              {en_q, wr_q, adr_q} <= {2'b10, REG_FIFO};
            end
          end else if (tmo_hit) begin
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bootload_seq.sv
// Randomized bench for spi_bootload_seq: bus responder, source driver and a transaction-list model.
`timescale 1ns/1ps
module tb_spi_bootload_seq;
  localparam int NW  = 256;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_b, start_i;
  logic [1:0]  op_i;
  logic [31:0] addr_i;
  logic [15:0] cmd_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] result_o;
  logic [15:0] src_dat_i;
  logic        src_valid_i, src_ready_o;
  logic [15:0] snk_dat_o;
  logic        snk_valid_o;
  logic [1:0]  bus_adr_o;
  logic [15:0] bus_dat_o;
  logic        bus_en_o, bus_wr_o;
  logic [15:0] bus_dat_i;
  logic        bus_valid_i;

  always #5 clk = ~clk;

  spi_bootload_seq #(.NWORDS(NW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start_i), .op_i(op_i), .addr_i(addr_i),
    .cmd_i(cmd_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .src_dat_i(src_dat_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .snk_dat_o(snk_dat_o), .snk_valid_o(snk_valid_o), .bus_adr_o(bus_adr_o),
    .bus_dat_o(bus_dat_o), .bus_en_o(bus_en_o), .bus_wr_o(bus_wr_o),
    .bus_dat_i(bus_dat_i), .bus_valid_i(bus_valid_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Observed traffic and model state
  logic [18:0] obs_q[$];
  logic [15:0] snk_q[$];
  logic [15:0] ret_q[$];
  int          done_cnt = 0;
  logic        done_err = 1'b0;
  int          src_idx = 0;
  bit          src_en = 0, src_hs = 0;
  int          rd_wait = -1;
  bit          no_resp = 0, fix_en = 0;
  logic [15:0] fix_dat = 16'h0;
  int          fix_dly = 0;
  logic [15:0] rsp;

  always @(negedge clk) begin
    if (src_hs) src_idx++;
    src_hs = 0;
    if (src_en && src_idx < NW) begin
      src_valid_i = ($urandom_range(0, 3) != 0);
      src_dat_i   = src_valid_i ? 16'(src_idx) : 16'($urandom);
    end else begin
      src_valid_i = 1'b0;
    end
    #1;
    src_hs = src_valid_i && src_ready_o;
    if (bus_en_o) obs_q.push_back({bus_wr_o, bus_adr_o, bus_wr_o ? bus_dat_o : 16'h0});
    if (snk_valid_o) snk_q.push_back(snk_dat_o);
    if (done_o) begin
      done_cnt++;
      done_err = err_o;
    end
    bus_valid_i = 1'b0;
    if (!rst_b) begin
      rd_wait = -1;
    end else if (rd_wait == 0) begin
      rsp = fix_en ? fix_dat : 16'($urandom);
      bus_valid_i = 1'b1;
      bus_dat_i   = rsp;
      ret_q.push_back(rsp);
      rd_wait = -1;
    end else if (rd_wait > 0) begin
      rd_wait--;
    end else if (!no_resp) begin
      bus_valid_i = ($urandom_range(0, 3) == 0);
      bus_dat_i   = 16'($urandom);
    end
    if (rst_b && bus_en_o && !bus_wr_o) begin
      rd_wait     = no_resp ? -1 : (fix_en ? fix_dly : int'($urandom_range(0, 3)));
      bus_valid_i = 1'($urandom_range(0, 1));
      bus_dat_i   = 16'($urandom);
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_err"}, err_o, 0);
    chk({nm, "_srdy"}, src_ready_o, 0);
    chk({nm, "_svld"}, snk_valid_o, 0);
    chk({nm, "_en"}, bus_en_o, 0);
    chk({nm, "_wr"}, bus_wr_o, 0);
    chk({nm, "_adr"}, bus_adr_o, 0);
    chk({nm, "_bdat"}, bus_dat_o, 0);
    chk({nm, "_result"}, result_o, 0);
    chk({nm, "_sdat"}, snk_dat_o, 0);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [15:0] c);
    @(negedge clk);
    obs_q.delete(); snk_q.delete(); ret_q.delete();
    done_cnt = 0; done_err = 0;
    start_i = 1'b1; op_i = op; addr_i = a; cmd_i = c;
    @(negedge clk); #2;
    start_i = 1'b0; addr_i = $urandom; cmd_i = 16'($urandom);
    chk("busy_acc", busy_o, 1);
  endtask

  // Waits for done_o; pokes start_i once while busy and once in the done cycle.
  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      start_i = (i == 2);
      op_i    = 2'($urandom);
      @(negedge clk); #2;
      i++;
    end
    start_i = 1'b1;
    op_i    = 2'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk("busy_end", busy_o, 0);
    chk("done_len", done_o, 0);
  endtask

  task automatic check_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [15:0] c);
    logic [18:0] exp_q[$];
    int nrd;
    if (op == 2'd2) exp_q.push_back({1'b1, 2'd0, 16'h8000});
    if (op == 2'd1) for (int i = 0; i < NW; i++) exp_q.push_back({1'b1, 2'd0, 16'(i)});
    if (op != 2'd3) begin
      exp_q.push_back({1'b1, 2'd1, a[15:0]});
      exp_q.push_back({1'b1, 2'd2, a[31:16]});
      exp_q.push_back({1'b1, 2'd3, c});
      exp_q.push_back({1'b0, 2'd3, 16'h0});
    end
    if (op == 2'd2) for (int i = 0; i < NW; i++) exp_q.push_back({1'b0, 2'd0, 16'h0});
    chk({nm, "_nbus"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_bus%0d", nm, i), obs_q[i], exp_q[i]);
    chk({nm, "_ndone"}, done_cnt, 1);
    chk({nm, "_err"}, done_err, (op == 2'd3));
    nrd = (op == 2'd3) ? 0 : ((op == 2'd2) ? NW + 1 : 1);
    chk({nm, "_nrsp"}, ret_q.size(), nrd);
    if (ret_q.size() > 0) chk({nm, "_result"}, result_o, ret_q[0]);
    chk({nm, "_nsnk"}, snk_q.size(), (op == 2'd2) ? NW : 0);
    for (int i = 0; i < snk_q.size() && i + 1 < ret_q.size(); i++)
      chk($sformatf("%s_snk%0d", nm, i), snk_q[i], ret_q[i + 1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [15:0] rc;
    int          i;
    rst_b = 1'b0; start_i = 1'b0; op_i = 2'd0; addr_i = '0; cmd_i = '0;
    src_valid_i = 1'b0; src_dat_i = '0; bus_valid_i = 1'b0; bus_dat_i = '0;
    repeat (3) @(negedge clk);
    #2;
    chk_zero("rst");

    // First start right on the first edge after reset release
    @(negedge clk);
    obs_q.delete(); done_cnt = 0;
    rst_b = 1'b1; start_i = 1'b1; op_i = 2'd3;
    @(negedge clk); #2;
    start_i = 1'b0;
    chk("first_busy", busy_o, 1);
    chk("first_done", done_o, 1);
    chk("first_err", err_o, 1);
    @(negedge clk); #2;
    chk("first_idle", busy_o, 0);
    chk("first_nbus", obs_q.size(), 0);

    fix_en = 1; fix_dat = 16'h0020; fix_dly = 10;
    launch(2'd0, 32'h0, 16'h9E9E);
    wait_done(200);
    check_op("cmd", 2'd0, 32'h0, 16'h9E9E);
    chk("cmd_res0020", result_o, 16'h0020);
    fix_en = 0;

    src_idx = 0; src_en = 1;
    launch(2'd1, 32'h0001_0000, 16'h0302);
    wait_done(5000);
    src_en = 0;
    check_op("prog", 2'd1, 32'h0001_0000, 16'h0302);

    launch(2'd2, 32'h0001_0000, 16'h0203);
    wait_done(5000);
    check_op("read", 2'd2, 32'h0001_0000, 16'h0203);

    launch(2'd3, 32'hDEAD_BEEF, 16'h1234);
    wait_done(50);
    check_op("ill", 2'd3, 32'hDEAD_BEEF, 16'h1234);

    for (int k = 0; k < 5; k++) begin
      rop = 2'($urandom); ra = $urandom; rc = 16'($urandom);
      src_idx = 0; src_en = (rop == 2'd1);
      launch(rop, ra, rc);
      wait_done(5000);
      src_en = 0;
      check_op($sformatf("rnd%0d", k), rop, ra, rc);
    end

    // Asynchronous reset in the middle of a PROGRAM page
    src_idx = 0; src_en = 1;
    launch(2'd1, 32'h0002_0000, 16'h0302);
    i = 0;
    while (src_idx < 100 && i < 2000) begin
      @(negedge clk); #2;
      i++;
    end
    chk("arst_reach100", (src_idx >= 100), 1);
    #1 rst_b = 1'b0;
    #1;
    chk_zero("arst");
    src_en = 0;
    @(negedge clk);
    rst_b = 1'b1;
    ra = $urandom; rc = 16'($urandom);
    launch(2'd0, ra, rc);
    wait_done(200);
    check_op("after_rst", 2'd0, ra, rc);

    // Bus never answers
    no_resp = 1;
    launch(2'd0, $urandom, 16'($urandom));
`ifdef SPI_BOOTLOAD_SEQ_TIMEOUT_EN
    wait_done(60);
    chk("tmo_ndone", done_cnt, 1);
    chk("tmo_err", done_err, 1);
`else
    repeat (60) @(negedge clk);
    #2;
    chk("hang_busy", busy_o, 1);
    chk("hang_ndone", done_cnt, 0);
`endif
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk); #2;
    chk_zero("rst2");
    rst_b = 1'b1;
    no_resp = 0;

    ra = $urandom; rc = 16'($urandom);
    launch(2'd0, ra, rc);
    wait_done(200);
    check_op("final", 2'd0, ra, rc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
